// File: rtl/mem_access_pkg.sv
// mem_access_pkg: shared FSM state encoding, load size codes and strobe helper
package mem_access_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2} state_t;
  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  function automatic logic [1:0] size_of(input logic [3:0] strb);
    logic [2:0] n;
    n = {2'b0, strb[0]} + {2'b0, strb[1]} + {2'b0, strb[2]} + {2'b0, strb[3]};
    return n == 3'd4 ? SZ_W : n == 3'd2 ? SZ_H : SZ_B;
  endfunction
endpackage

// File: rtl/mem_access_load_align.sv
// load_align: shifts a read beat down to its lowest enabled byte lane and extends it
//   i_rdata  raw bus read data
//   i_strb   byte strobes of the load (lowest set bit = lane, popcount = size)
//   i_signed sign-extend when high, zero-extend when low
//   o_data   aligned 32-bit load result
module load_align
  import mem_access_pkg::*;
(
  input  logic [31:0] i_rdata,
  input  logic [3:0]  i_strb,
  input  logic        i_signed,
  output logic [31:0] o_data
);
  logic [1:0]  w_lane;
  logic [1:0]  w_size;
  logic [31:0] w_sh;
  always_comb begin
    w_lane = i_strb[0] ? 2'd0 : i_strb[1] ? 2'd1 : i_strb[2] ? 2'd2 : i_strb[3] ? 2'd3 : 2'd0;
    w_size = size_of(i_strb);
    w_sh   = i_rdata >> {w_lane, 3'b000};
    o_data = w_size == SZ_W ? w_sh :
             w_size == SZ_H ? {{16{i_signed & w_sh[15]}}, w_sh[15:0]} :
                              {{24{i_signed & w_sh[7]}}, w_sh[7:0]};
  end
endmodule

// File: rtl/mem_access.sv
// mem_access: memory stage issuing load/store bus requests and producing register writeback
//   i_clk/i_rst_n           clock, async active-low reset
//   i_reg_w_*               ALU writeback request (rd=0 means none)
//   i_mem_r_*/i_mem_w_*     load/store requests from execute
//   o_stall                 hold execute and upstream stages
//   o_mem_req_*/i_mem_req_ready  bus request channel
//   i_mem_resp_*            single-beat read response, always accepted
//   o_wb_rd/o_wb_data       registered register-file write / forwarding port B
module mem_access
  import mem_access_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [4:0]  i_reg_w_rd,
  input  logic [31:0] i_reg_w_data,
  input  logic        i_mem_r_valid,
  input  logic [4:0]  i_mem_r_rd,
  input  logic [31:0] i_mem_r_addr,
  input  logic [3:0]  i_mem_r_strb,
  input  logic        i_mem_r_signed,
  input  logic        i_mem_w_valid,
  input  logic [31:0] i_mem_w_addr,
  input  logic [3:0]  i_mem_w_strb,
  input  logic [31:0] i_mem_w_data,
  output logic        o_stall,
  output logic        o_mem_req_valid,
  output logic        o_mem_req_we,
  output logic [31:0] o_mem_req_addr,
  output logic [3:0]  o_mem_req_strb,
  output logic [31:0] o_mem_req_wdata,
  input  logic        i_mem_req_ready,
  input  logic        i_mem_resp_valid,
  input  logic [31:0] i_mem_resp_rdata,
  output logic [4:0]  o_wb_rd,
  output logic [31:0] o_wb_data
);
  state_t      r_state;
  logic        r_mem_req_valid;
  logic        r_mem_req_we;
  logic [31:0] r_mem_req_addr;
  logic [3:0]  r_mem_req_strb;
  logic [31:0] r_mem_req_wdata;
  logic [4:0]  r_ld_rd;
  logic        r_ld_signed;
  logic        r_pend;
  logic [4:0]  r_pend_rd;
  logic [31:0] r_pend_data;
  logic [4:0]  r_wb_rd;
  logic [31:0] r_wb_data;
  logic        w_mem;
  logic        w_stall;
  logic        w_ld_done;
  logic        w_direct;
  logic [31:0] w_alu_data;
  logic [31:0] w_ld_data;
  logic [4:0]  w_wb_rd;
  logic [31:0] w_wb_data;
  load_align u_align (
    .i_rdata  (i_mem_resp_rdata),
    .i_strb   (r_mem_req_strb),
    .i_signed (r_ld_signed),
    .o_data   (w_ld_data)
  );
  // An ALU op captured on a completion edge cannot write back on that edge, so it
  // is parked in r_pend and written on the following edge; an ALU op arriving
  // while r_pend is occupied takes its place, and a bubble or mem op drains it.
  always_comb begin
    w_mem      = i_mem_r_valid | i_mem_w_valid;
    w_stall    = (r_state == REQ && !(i_mem_req_ready && r_mem_req_we)) ||
                 (r_state == WAIT && !i_mem_resp_valid);
    w_ld_done  = r_state == WAIT && i_mem_resp_valid;
    w_direct   = r_state == IDLE && !r_pend;
    w_alu_data = i_reg_w_rd != 5'd0 ? i_reg_w_data : 32'd0;
    w_wb_rd    = w_ld_done ? r_ld_rd :
                 (r_state == IDLE && r_pend) ? r_pend_rd :
                 (w_direct && !w_mem) ? i_reg_w_rd : 5'd0;
    w_wb_data  = w_ld_done ? (r_ld_rd != 5'd0 ? w_ld_data : 32'd0) :
                 (r_state == IDLE && r_pend) ? r_pend_data :
                 (w_direct && !w_mem) ? w_alu_data : 32'd0;
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state         <= IDLE;
      r_mem_req_valid <= 1'b0;
      r_mem_req_we    <= 1'b0;
      r_mem_req_addr  <= 32'd0;
      r_mem_req_strb  <= 4'd0;
      r_mem_req_wdata <= 32'd0;
      r_ld_rd         <= 5'd0;
      r_ld_signed     <= 1'b0;
      r_pend          <= 1'b0;
      r_pend_rd       <= 5'd0;
      r_pend_data     <= 32'd0;
      r_wb_rd         <= 5'd0;
      r_wb_data       <= 32'd0;
    end else if (w_stall) begin
      r_wb_rd   <= 5'd0;
      r_wb_data <= 32'd0;
      if (r_state == REQ && i_mem_req_ready) begin
        r_state         <= WAIT;
        r_mem_req_valid <= 1'b0;
      end
    end else begin
      r_state         <= w_mem ? REQ : IDLE;
      r_mem_req_valid <= w_mem;
      r_wb_rd         <= w_wb_rd;
      r_wb_data       <= w_wb_data;
      r_pend          <= !w_mem && !w_direct && i_reg_w_rd != 5'd0;
      r_pend_rd       <= i_reg_w_rd;
      r_pend_data     <= w_alu_data;
      if (w_mem) begin
        r_mem_req_we    <= !i_mem_r_valid;
        r_mem_req_addr  <= i_mem_r_valid ? i_mem_r_addr : i_mem_w_addr;
        r_mem_req_strb  <= i_mem_r_valid ? i_mem_r_strb : i_mem_w_strb;
        r_mem_req_wdata <= i_mem_r_valid ? 32'd0 : i_mem_w_data;
        r_ld_rd         <= i_mem_r_valid ? i_mem_r_rd : 5'd0;
        r_ld_signed     <= i_mem_r_valid && i_mem_r_signed;
      end
    end
  end
  assign o_stall         = w_stall;
  assign o_mem_req_valid = r_mem_req_valid;
  assign o_mem_req_we    = r_mem_req_we;
  assign o_mem_req_addr  = r_mem_req_addr;
  assign o_mem_req_strb  = r_mem_req_strb;
  assign o_mem_req_wdata = r_mem_req_wdata;
  assign o_wb_rd         = r_wb_rd;
  assign o_wb_data       = r_wb_data;
endmodule
